// File: rtl/sm_trace_pkg.sv
// Shared encodings and helpers for the sm_cpu execution trace recorder.
package sm_trace_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } traceState_e;

  typedef enum logic [1:0] {
    TrigFree  = 2'd0,
    TrigPc    = 2'd1,
    TrigInstr = 2'd2,
    TrigRsvd  = 2'd3
  } trigMode_e;

  function automatic logic maskMatch(input logic [31:0] value, input logic [31:0] cmpVal,
                                     input logic [31:0] mask);
    return ((value ^ cmpVal) & mask) == 32'd0;
  endfunction

  // Mask covering the low w bits, so fields narrower than 32 ignore the upper compare bits.
  function automatic logic [31:0] lowMask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
module sm_trace_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array left unreset so it maps onto memory primitives.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData <= '0;
    end else begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/sm_trace_buf.sv
// Execution trace recorder for sm_cpu: circular capture of {pc, instr, reg} with
// PC/instruction trigger, post-trigger window and sample-count timeout.
module sm_trace_buf
  import sm_trace_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned REG_W     = 32,
  parameter int unsigned POST_TRIG = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sampleEn,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic [REG_W-1:0]   regVal,
  input  logic               arm,
  input  logic               clear,
  input  logic [1:0]         trigMode,
  input  logic [31:0]        trigValue,
  input  logic [31:0]        trigMask,
  input  logic [CNT_W-1:0]   cycleLimit,
  input  logic [ADDR_W-1:0]  rdIdx,
  output logic [PC_W-1:0]    rdPc,
  output logic [INSTR_W-1:0] rdInstr,
  output logic [REG_W-1:0]   rdReg,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               timeout,
  output logic [ADDR_W:0]    entries,
  output logic [CNT_W-1:0]   cycleCount
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = PC_W + INSTR_W + REG_W;
  localparam int unsigned ENT_W  = ADDR_W + 1;
  localparam logic [ADDR_W:0]   FullCnt  = ENT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PostInit = ADDR_W'(POST_TRIG);
  localparam logic [31:0]       PcMask   = lowMask(PC_W);
  localparam logic [31:0]       InMask   = lowMask(INSTR_W);

  traceState_e       stateQ, stateD;
  logic [ADDR_W-1:0] wrPtrQ, wrPtrD;
  logic [ADDR_W:0]   entriesQ, entriesD;
  logic [CNT_W-1:0]  cycleCountQ, cycleCountD;
  logic [ADDR_W-1:0] postCntQ, postCntD;
  logic              triggeredQ, triggeredD;
  logic              timeoutQ, timeoutD;

  logic              hit, limitHit, wrEn, restart, trigFire, limitFire;
  logic [CNT_W-1:0]  cycleInc;
  logic [ADDR_W-1:0] oldest, rdAddr;
  logic [DATA_W-1:0] rdData;

  always_comb begin
    hit = 1'b0;
    unique case (trigMode_e'(trigMode))
      TrigPc:    hit = maskMatch(32'(pc), trigValue, trigMask & PcMask);
      TrigInstr: hit = maskMatch(32'(instr), trigValue, trigMask & InMask);
      default:   hit = 1'b0;
    endcase
  end

  assign cycleInc = (cycleCountQ == '1) ? cycleCountQ : cycleCountQ + CNT_W'(1);
  assign limitHit = (cycleLimit != '0) && (cycleInc == cycleLimit);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    if (clear) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle, StDone: if (arm) stateD = StArmed;
        StArmed: begin
          if (sampleEn) begin
            if (hit) begin
              stateD = (POST_TRIG == 0) ? StDone : StPost;
            end else if (limitHit) begin
              stateD = StDone;
            end
          end
        end
        StPost: if (sampleEn && postCntQ == ADDR_W'(1)) stateD = StDone;
        default: stateD = StIdle;
      endcase
    end
  end

  // FSM: control outputs
  always_comb begin
    wrEn      = !clear && sampleEn && (stateQ == StArmed || stateQ == StPost);
    restart   = clear || (arm && (stateQ == StIdle || stateQ == StDone));
    trigFire  = !clear && sampleEn && (stateQ == StArmed) && hit;
    limitFire = !clear && sampleEn && (stateQ == StArmed) && !hit && limitHit;
  end

  always_comb begin
    wrPtrD      = wrPtrQ;
    entriesD    = entriesQ;
    cycleCountD = cycleCountQ;
    postCntD    = postCntQ;
    triggeredD  = triggeredQ;
    timeoutD    = timeoutQ;
    if (restart) begin
      wrPtrD      = '0;
      entriesD    = '0;
      cycleCountD = '0;
      postCntD    = '0;
      triggeredD  = 1'b0;
      timeoutD    = 1'b0;
    end else begin
      if (wrEn) begin
        wrPtrD      = wrPtrQ + ADDR_W'(1);
        entriesD    = (entriesQ == FullCnt) ? entriesQ : entriesQ + ENT_W'(1);
        cycleCountD = cycleInc;
        if (stateQ == StPost) postCntD = postCntQ - ADDR_W'(1);
      end
      if (trigFire) begin
        triggeredD = 1'b1;
        postCntD   = PostInit;
      end
      if (limitFire) timeoutD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ      <= '0;
      entriesQ    <= '0;
      cycleCountQ <= '0;
      postCntQ    <= '0;
      triggeredQ  <= 1'b0;
      timeoutQ    <= 1'b0;
    end else begin
      wrPtrQ      <= wrPtrD;
      entriesQ    <= entriesD;
      cycleCountQ <= cycleCountD;
      postCntQ    <= postCntD;
      triggeredQ  <= triggeredD;
      timeoutQ    <= timeoutD;
    end
  end

  // Once the buffer has wrapped, the oldest sample sits at the write pointer.
  assign oldest = (entriesQ == FullCnt) ? wrPtrQ : '0;
  assign rdAddr = oldest + rdIdx;

  sm_trace_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uRam (
    .clk   (clk),
    .rst_n (rst_n),
    .wrEn  (wrEn),
    .wrAddr(wrPtrQ),
    .wrData({pc, instr, regVal}),
    .rdAddr(rdAddr),
    .rdData(rdData)
  );

  assign rdPc       = rdData[DATA_W-1 -: PC_W];
  assign rdInstr    = rdData[REG_W +: INSTR_W];
  assign rdReg      = rdData[REG_W-1:0];
  assign state      = stateQ;
  assign triggered  = triggeredQ;
  assign timeout    = timeoutQ;
  assign entries    = entriesQ;
  assign cycleCount = cycleCountQ;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Directed bench for sm_trace_buf: a POST_TRIG=8 instance and a POST_TRIG=0 instance
// driven by the same stimulus.
module tb_sm_trace_buf;

  logic        clk;
  logic        rst_n;
  logic        sampleEn;
  logic [31:0] pc, instr, regVal;
  logic        arm, clear;
  logic [1:0]  trigMode;
  logic [31:0] trigValue, trigMask;
  logic [15:0] cycleLimit;
  logic [3:0]  rdIdx;

  logic [31:0] rdPc, rdInstr, rdReg;
  logic [1:0]  state;
  logic        triggered, timeout;
  logic [4:0]  entries;
  logic [15:0] cycleCount;

  logic [31:0] rdPc0, rdInstr0, rdReg0;
  logic [1:0]  state0;
  logic        triggered0, timeout0;
  logic [4:0]  entries0;
  logic [15:0] cycleCount0;

  int checks   = 0;
  int failures = 0;

  sm_trace_buf #(.POST_TRIG(8)) dut (
    .clk(clk), .rst_n(rst_n), .sampleEn(sampleEn), .pc(pc), .instr(instr), .regVal(regVal),
    .arm(arm), .clear(clear), .trigMode(trigMode), .trigValue(trigValue), .trigMask(trigMask),
    .cycleLimit(cycleLimit), .rdIdx(rdIdx), .rdPc(rdPc), .rdInstr(rdInstr), .rdReg(rdReg),
    .state(state), .triggered(triggered), .timeout(timeout), .entries(entries),
    .cycleCount(cycleCount)
  );

  sm_trace_buf #(.POST_TRIG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sampleEn(sampleEn), .pc(pc), .instr(instr), .regVal(regVal),
    .arm(arm), .clear(clear), .trigMode(trigMode), .trigValue(trigValue), .trigMask(trigMask),
    .cycleLimit(cycleLimit), .rdIdx(rdIdx), .rdPc(rdPc0), .rdInstr(rdInstr0), .rdReg(rdReg0),
    .state(state0), .triggered(triggered0), .timeout(timeout0), .entries(entries0),
    .cycleCount(cycleCount0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic sample(input logic [31:0] p, input logic [31:0] i);
    sampleEn = 1'b1;
    pc = p;
    instr = i;
    regVal = ~p;
    step();
    sampleEn = 1'b0;
  endtask

  task automatic readAt(input logic [3:0] idx);
    rdIdx = idx;
    step();
  endtask

  initial begin
    logic [31:0] pcv;
    int          cyc;
    logic        done;

    rst_n = 1'b0; sampleEn = 1'b0; pc = '0; instr = '0; regVal = '0;
    arm = 1'b0; clear = 1'b0; trigMode = 2'd0; trigValue = '0; trigMask = '0;
    cycleLimit = '0; rdIdx = '0;
    #2;
    check("rst_state", 64'(state), 64'd0);
    check("rst_entries", 64'(entries), 64'd0);
    check("rst_flags", 64'({triggered, timeout}), 64'd0);
    check("rst_rdPc", 64'(rdPc), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a free-run capture
    pulseArm();
    check("arm_state", 64'(state), 64'd1);
    for (int k = 0; k < 5; k++) sample(32'h10 + 32'(k), 32'h0);
    check("pre_rst_entries", 64'(entries), 64'd5);
    check("pre_rst_count", 64'(cycleCount), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 64'(state), 64'd0);
    check("async_rst_entries", 64'(entries), 64'd0);
    check("async_rst_count", 64'(cycleCount), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_state", 64'(state), 64'd0);

    // PC trigger with buffer wrap and 8 post-trigger samples
    trigMode = 2'd1; trigValue = 32'h40; trigMask = 32'hFFFF_FFFF; cycleLimit = 16'd0;
    pulseArm();
    pcv = 32'h30;
    done = 1'b0;
    for (cyc = 0; cyc < 64; cyc++) begin
      sampleEn = 1'b1; pc = pcv; instr = pcv + 32'h1000; regVal = ~pcv;
      step();
      if (state == 2'd3) begin
        done = 1'b1;
        break;
      end
      pcv = pcv + 32'd1;
    end
    sampleEn = 1'b0;
    check("trig_done", 64'(done), 64'd1);
    check("trig_last_pc", 64'(pcv), 64'h48);
    check("trig_flag", 64'(triggered), 64'd1);
    check("trig_timeout", 64'(timeout), 64'd0);
    check("trig_entries", 64'(entries), 64'd16);
    for (int k = 0; k < 3; k++) sample(32'hDEAD, 32'h0);
    check("done_hold_state", 64'(state), 64'd3);
    check("done_hold_entries", 64'(entries), 64'd16);
    readAt(4'd0);
    check("rd0_pc", 64'(rdPc), 64'h39);
    check("rd0_instr", 64'(rdInstr), 64'h1039);
    check("rd0_reg", 64'(rdReg), 64'hFFFF_FFC6);
    readAt(4'd15);
    check("rd15_pc", 64'(rdPc), 64'h48);
    readAt(4'd7);
    check("rd7_pc", 64'(rdPc), 64'h40);

    // Timeout in free-run with a gappy sampleEn
    trigMode = 2'd0; cycleLimit = 16'd5;
    pulseArm();
    check("rearm_entries", 64'(entries), 64'd0);
    done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      sampleEn = (cyc % 2 == 0);
      pc = 32'h100 + 32'(cyc / 2);
      step();
      if (state == 2'd3) begin
        done = 1'b1;
        break;
      end
    end
    sampleEn = 1'b0;
    check("to_done", 64'(done), 64'd1);
    check("to_cycle", 64'(cyc), 64'd8);
    check("to_flag", 64'(timeout), 64'd1);
    check("to_trig", 64'(triggered), 64'd0);
    check("to_entries", 64'(entries), 64'd5);
    check("to_count", 64'(cycleCount), 64'd5);
    readAt(4'd4);
    check("to_rd4_pc", 64'(rdPc), 64'h104);
    readAt(4'd0);
    check("to_rd0_pc", 64'(rdPc), 64'h100);

    // Trigger and cycle limit on the same sample
    pulseClear();
    check("clr_state", 64'(state), 64'd0);
    check("clr_entries", 64'(entries), 64'd0);
    check("clr_timeout", 64'(timeout), 64'd0);
    trigMode = 2'd1; trigValue = 32'h202; trigMask = 32'hFFFF_FFFF; cycleLimit = 16'd3;
    pulseArm();
    sample(32'h200, 32'h0);
    sample(32'h201, 32'h0);
    check("prio_armed0", 64'(state0), 64'd1);
    sample(32'h202, 32'h0);
    check("prio_state0", 64'(state0), 64'd3);
    check("prio_trig0", 64'(triggered0), 64'd1);
    check("prio_to0", 64'(timeout0), 64'd0);
    check("prio_entries0", 64'(entries0), 64'd3);
    check("prio_state_post", 64'(state), 64'd2);
    check("prio_to_post", 64'(timeout), 64'd0);
    check("prio_count", 64'(cycleCount), 64'd3);

    // clear and arm together while in POST
    clear = 1'b1; arm = 1'b1;
    step();
    clear = 1'b0; arm = 1'b0;
    check("clrarm_state", 64'(state), 64'd0);
    check("clrarm_entries", 64'(entries), 64'd0);
    check("clrarm_trig", 64'(triggered), 64'd0);
    pulseArm();
    check("rearm_state", 64'(state), 64'd1);
    check("rearm_count", 64'(cycleCount), 64'd0);
    sample(32'h300, 32'h0);
    check("rearm_count1", 64'(cycleCount), 64'd1);
    check("rearm_entries1", 64'(entries), 64'd1);

    // Instruction match with upper-half mask
    pulseClear();
    trigMode = 2'd2; trigValue = 32'h2402_0000; trigMask = 32'hFFFF_0000; cycleLimit = 16'd0;
    pulseArm();
    sample(32'h400, 32'h0000_0013);
    sample(32'h401, 32'h2403_0005);
    sample(32'h402, 32'h8C00_0000);
    check("im_no_trig", 64'(state0), 64'd1);
    sample(32'h403, 32'h2402_0005);
    check("im_state0", 64'(state0), 64'd3);
    check("im_trig0", 64'(triggered0), 64'd1);
    check("im_entries0", 64'(entries0), 64'd4);
    check("im_state_post", 64'(state), 64'd2);
    readAt(4'd3);
    check("im_rd3_instr", 64'(rdInstr0), 64'h2402_0005);
    readAt(4'd1);
    check("im_rd1_instr", 64'(rdInstr0), 64'h2403_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_trace_buf.md
Name: sm_trace_buf

Overview:
Synthesizable on-chip execution trace recorder for the sm_cpu core. Each enabled CPU cycle it captures {pc, instr, watched register} into a circular buffer. A trigger condition (PC or instruction match) freezes the capture after a programmable number of post-trigger samples; a cycle-limit timeout stops it otherwise. Sits beside sm_cpu in sm_top; the buffer can be read back after capture.

Parameters:
ADDR_W, 4, log2 of buffer depth (DEPTH = 2**ADDR_W entries)
PC_W, 32, captured PC width
INSTR_W, 32, captured instruction width
REG_W, 32, captured watched-register width
POST_TRIG, 8, samples recorded after the trigger sample; legal range 0..DEPTH-1
CNT_W, 16, width of the cycle counter and the cycle limit

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sampleEn  in  1  one CPU step is valid this cycle; captures happen only when high
pc  in  PC_W  current CPU PC
instr  in  INSTR_W  current instruction
regVal  in  REG_W  watched register value (e.g. rf[2])
arm  in  1  pulse: start capture
clear  in  1  pulse: abort and return to IDLE
trigMode  in  2  0 = free-run (no trigger), 1 = PC match, 2 = instr match, 3 = reserved, behaves as 0
trigValue  in  32  compare value; low PC_W/INSTR_W bits used
trigMask  in  32  compare mask; bit set = compared
cycleLimit  in  CNT_W  timeout in samples while ARMED; 0 = no timeout
rdIdx  in  ADDR_W  read index relative to oldest entry
rdPc  out  PC_W  readout, 1-cycle latency
rdInstr  out  INSTR_W  readout, 1-cycle latency
rdReg  out  REG_W  readout, 1-cycle latency
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  out  1  capture ended by trigger
timeout  out  1  capture ended by cycle limit
entries  out  ADDR_W+1  valid entries, 0..DEPTH
cycleCount  out  CNT_W  samples taken since arm

Behaviour:
- Reset: state=IDLE; all outputs 0; pointers/counters 0. Buffer contents undefined.
- IDLE: no capture. arm -> ARMED; wrPtr, entries, cycleCount, triggered, timeout cleared on the arm cycle.
- ARMED: each sampleEn cycle writes {pc,instr,regVal} at wrPtr; wrPtr wraps modulo DEPTH; entries saturates at DEPTH; cycleCount increments, saturating at all-ones.
- Trigger hit = sampleEn & ((in ^ trigValue) & trigMask) == 0 on the selected field, in ARMED only. Hit sample is written. POST_TRIG=0 -> DONE next cycle; else -> POST with postCnt=POST_TRIG.
- POST: each sampleEn cycle writes and decrements postCnt; at the write that brings postCnt to 0 -> DONE. Trigger matches ignored. No timeout in POST.
- Timeout: in ARMED, when cycleLimit!=0 and a sampleEn write makes cycleCount==cycleLimit -> DONE, timeout=1. Trigger hit and limit on the same sample: trigger wins (timeout stays 0).
- DONE: no writes; flags and entries hold. arm restarts the capture, as from IDLE.
- clear: any state -> IDLE next cycle; flags/entries cleared. clear and arm in the same cycle: clear wins.
- Readout: oldest = (entries==DEPTH) ? wrPtr : 0; physical address = oldest + rdIdx mod DEPTH; registered output valid the cycle after rdIdx is applied. Reads are legal in any state. rdIdx >= entries returns undefined data.
- Free-run mode ends only by timeout or clear; with cycleLimit=0 it records indefinitely and the buffer keeps the last DEPTH samples.
- Changing trigMode, trigValue, or trigMask while ARMED takes effect on the next sample.

Decomposition:
- sm_trace_pkg (or sm_trace.vh defines): state encodings, trigMode encodings.
- One sub-module: sm_trace_ram. Simple dual-port RAM, DEPTH x (PC_W+INSTR_W+REG_W), synchronous write and registered read. Keeps the FSM and pointer logic separate from inferable memory.

Test Plan:
- Reset mid-ARMED (rst_n low for 1 cycle after 5 samples) -> state=0, entries=0, cycleCount=0 immediately (asynchronous).
- Trigger with wrap: DEPTH=16, POST_TRIG=8, trigMode=1, mask=FFFFFFFF, value=0x40, pc increments by 1 starting at 0x30, arm -> DONE after pc=0x48 written; triggered=1, entries=16; rdIdx=0 gives pc 0x39, rdIdx=15 gives 0x48.
- Timeout: trigMode=0, cycleLimit=5, sampleEn toggles 1/0 -> DONE after the 5th enabled sample; timeout=1, entries=5, rdIdx=4 gives the 5th PC.
- Priority: cycleLimit=3 and trigger matching on the 3rd sample, POST_TRIG=0 -> triggered=1, timeout=0, entries=3.
- Instr match with mask: trigMode=2, value=0x24020000, mask=FFFF0000, instr stream includes 0x24020005 -> triggers on that sample; an earlier 0x24030005 does not trigger.
- clear and arm asserted together in POST -> IDLE, entries=0; a following arm alone -> ARMED, cycleCount restarts at 0.
